bcd_down_timer: RTL and testbench

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer.sv | 169 ++++++++++++++++
 tb/tb_bcd_down_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Loadable BCD down-counter with a small run-control FSM
//   (IDLE, RUN, PAUSE, DONE). Commands are prioritised
//   load > stop > start and evaluated every cycle. All outputs are registered.
//
//   Optional feature macro: BCD_TIMER_AUTO_RELOAD_EN
//     When the macro is defined, the terminal event still pulses tc.
//     The FSM stays in RUN, and the next enabled cycle reloads count from the
//     value last loaded. A reload value of zero still ends in DONE.
//     When the macro is undefined, the terminal event always ends in DONE and
//     no reload register is built.
//
//   Valid/ready semantics: none. Every command is a level that is sampled on
//   each rising clk edge. Nothing is ever back-pressured.
//
// Ports
//   clk       rising-edge clock
//   clr       asynchronous active-low reset
//   en        count enable; it only matters in RUN
//   load      parallel load; it is honoured in every state
//   load_val  BCD load value, with digit 0 in [3:0]; digits above 9 clamp to 9
//   start     begin or resume counting
//   stop      pause counting
//   count     registered BCD count
//   tc        one-cycle pulse, high while count first shows 0
//   busy      high in RUN and PAUSE
//   done      high in DONE
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                busy,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   count_next;
  logic           tc_next;
  logic [W-1:0]   load_clean;
  logic [W-1:0]   count_dec;
  logic           count_zero;
  logic           count_one;

  // Clamp every nibble above 9 down to 9, so count never holds a non-BCD digit.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement. A zero digit wraps to 9 and passes the
  // borrow on to the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_clean = sanitize(load_val);
  assign count_dec  = bcd_dec(count);
  assign count_zero = (count == '0);
  assign count_one  = (count == W'(1));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      reload_q <= '0;
    else if (load) reload_q <= load_clean;
  end
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    tc_next    = 1'b0;
    if (load) begin
      // load beats everything, including a terminal event in the same cycle.
      state_next = IDLE;
      count_next = load_clean;
    end else begin
      case (state)
        IDLE: begin
          if (start && !count_zero) state_next = RUN;
        end
        RUN: begin
          // stop beats a coincident terminal event: no decrement and no tc.
          if (stop) begin
            state_next = PAUSE;
          end else if (en) begin
            if (count_one) begin
              count_next = '0;
              tc_next    = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              if (reload_q == '0) state_next = DONE;
`else
              state_next = DONE;
`endif
            end else begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              // After the terminal event count sits at 0 in RUN, and the next
              // enabled edge restarts the count from the reload register.
              if (count_zero) count_next = reload_q;
              else
`endif
              count_next = count_dec;
            end
          end
        end
        PAUSE: begin
          if (!stop && start) state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      tc    <= tc_next;
      busy  <= (state_next == RUN) || (state_next == PAUSE);
      done  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer
//   Directed-vector bench for bcd_down_timer with DIGITS=2. Expected values
//   are written by hand from the counter's described behaviour. When the
//   design is built with BCD_TIMER_AUTO_RELOAD_EN, the bench switches its
//   terminal-event expectations to match that build.
module tb_bcd_down_timer;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       clr;
  logic       en, load, start, stop;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc, busy, done;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seq37 [11] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                             8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] seq39 [9]  = '{8'h04, 8'h04, 8'h03, 8'h03, 8'h02, 8'h02,
                             8'h01, 8'h01, 8'h00};

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic t,
                            input logic b, input logic d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"},    32'(tc),    32'(t));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    #3;
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    tick();

    // load 12 then count down to 00 with en held high
    do_load(8'h12);
    expect_out("t37.load", 8'h12, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    do_start();
    expect_out("t37.start", 8'h12, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      expect_out($sformatf("t37.step%0d", i), seq37[i], 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_out("t37.term", 8'h00, 1'b1, AUTO, !AUTO);
    tick();
    expect_out("t37.after", AUTO ? 8'h12 : 8'h00, 1'b0, AUTO, !AUTO);
`ifndef BCD_TIMER_AUTO_RELOAD_EN
    // DONE ignores start and stop
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    expect_out("done.ignore", 8'h00, 1'b0, 1'b0, 1'b1);
`endif
    en = 1'b0;

    // digit clamping (this load also exits DONE)
    do_load(8'h3C);
    expect_out("t38.3C", 8'h39, 1'b0, 1'b0, 1'b0);
    do_load(8'hFF);
    expect_out("t38.FF", 8'h99, 1'b0, 1'b0, 1'b0);
    do_load(8'hA4);
    expect_out("t38.A4", 8'h94, 1'b0, 1'b0, 1'b0);

    // start with count 00 is ignored
    do_load(8'h00);
    do_start();
    expect_out("zero.start", 8'h00, 1'b0, 1'b0, 1'b0);

    // en toggling 1,0,1,0 ...
    do_load(8'h05);
    do_start();
    for (int i = 0; i < 9; i++) begin
      en = (i % 2 == 0);
      tick();
      expect_out($sformatf("t39.c%0d", i), seq39[i], (i == 8), (i != 8) || AUTO,
                 (i == 8) && !AUTO);
    end
    en = 1'b0;

    // pause at 02, hold 4 cycles, resume
    do_load(8'h03);
    en = 1'b1;
    do_start();
    tick();
    expect_out("t40.run", 8'h02, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_out("t40.pause0", 8'h02, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("t40.pause%0d", i), 8'h02, 1'b0, 1'b1, 1'b0);
    end
    do_start();
    expect_out("t40.resume", 8'h02, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t40.01", 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t40.00", 8'h00, 1'b1, AUTO, !AUTO);
    tick();
    expect_out("t40.after", AUTO ? 8'h03 : 8'h00, 1'b0, AUTO, !AUTO);

    // stop coincident with the terminal event wins
    do_load(8'h01);
    do_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_out("t27.stop", 8'h01, 1'b0, 1'b1, 1'b0);
    do_start();
    tick();
    expect_out("t27.term", 8'h00, 1'b1, AUTO, !AUTO);

    // load coincident with the terminal event wins
    do_load(8'h01);
    do_start();
    do_load(8'h07);
    expect_out("t28.load", 8'h07, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-RUN
    do_load(8'h02);
    do_start();
    tick();
    expect_out("t41.run", 8'h01, 1'b0, 1'b1, 1'b0);
    #2 clr = 1'b0;
    #1;
    expect_out("t41.clr", 8'h00, 1'b0, 1'b0, 1'b0);
    #3 clr = 1'b1;
    tick();
    expect_out("t41.idle", 8'h00, 1'b0, 1'b0, 1'b0);
    do_start();
    expect_out("t41.start0", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    // auto-reload: 02,01,00,02,01,00 ...
    do_load(8'h02);
    do_start();
    tick(); expect_out("t42.a01", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("t42.a00", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("t42.b02", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("t42.b01", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("t42.b00", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("t42.c02", 8'h02, 1'b0, 1'b1, 1'b0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
